id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode stage of the five-stage pipeline, directly downstream of instruction fetch. Consumes the IF/ID pipeline register (PC+4 and instruction word), decodes control, reads the 32×32 register file, and sign-extends the immediate. Accepts write-back from WB and registers everything into the ID/EX pipeline register. Squashes its own output when MEM resolves a taken branch.

## Interface
- FLUSH_ON_BRANCH, default 1: when 1, a taken branch (MEM_ctrl_pc_src_in) zeroes the ID/EX control bits.
- clk_in  input  1  single clock; all state updates on posedge.
- n_rst_in  input  1  asynchronous, active-low reset.
- IFID_pc_in  input  32  PC+4 of the instruction in decode.
- IFID_ir_in  input  32  instruction word.
- MEM_ctrl_pc_src_in  input  1  taken branch resolved in MEM.
- WB_reg_write_in  input  1  write-back enable.
- WB_write_reg_in  input  5  write-back destination.
- WB_write_data_in  input  32  write-back data.
- IDEX_pc_out  output  32  forwarded PC+4.
- IDEX_rd1_out, IDEX_rd2_out  output  32 each  rs / rt read data.
- IDEX_imm_out  output  32  sign-extended ir[15:0]; funct is imm[5:0].
- IDEX_rt_out, IDEX_rd_out  output  5 each  ir[20:16], ir[15:11].
- IDEX_ctrl_out  output  9  {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op[1:0]}.

## Operation
- Decode on opcode ir[31:26]:
  - R-type 000000: reg_dst=1, reg_write=1, alu_op=10.
  - lw 100011: alu_src=1, mem_to_reg=1, reg_write=1, mem_read=1, alu_op=00.
  - sw 101011: alu_src=1, mem_write=1, alu_op=00.
  - beq 000100: branch=1, alu_op=01.
  - Any other opcode: all-zero control (bubble).
- Register file: 32 entries. Entry 0 reads 0 always; writes to it are ignored. Written on posedge when WB_reg_write_in=1.
- Read addresses are ir[25:21] (rs) and ir[20:16] (rt), read combinationally and registered into IDEX.
- Flush: FLUSH_ON_BRANCH=1 and MEM_ctrl_pc_src_in=1 at an edge → IDEX_ctrl_out<=0. Data fields still load. Upstream IF handles its own redirect.
- All-zero instruction (0x00000000) decodes as R-type with rd=0. This write is harmless.

## Timing
- Reset (async, on n_rst_in low): all IDEX outputs = 0 and all 32 registers = 0. Held until the first posedge after release.
- Latency: IFID inputs appear on IDEX outputs 1 cycle later. There is no stall; a new instruction is accepted every cycle.
- WB write is visible in the array from the cycle after the edge.
- Same-cycle WB write and ID read of the same nonzero register: behaviour depends on the ID_BYPASS_EN macro (see Configuration).
- Simultaneous flush and WB write: both take effect; a flush never blocks write-back.
- Reset asserted mid-operation clears the register file too. Software must reinitialise.

## Configuration
- ID_BYPASS_EN defined: the read port returns WB_write_data_in when WB_reg_write_in=1, the WB address equals the read address, and the address is ≠0. This is write-through, equivalent to write-first-half/read-second-half.
- ID_BYPASS_EN undefined: the read port returns the stored value (pre-write). Software must allow 3 intervening instructions between a write and a dependent read.

## Structure
- Shared package / header holds:
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ.
  - alu_op encodings: ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10.
  - Control-bit index constants for the 9-bit control vector.
- One sub-module: regfile (2 combinational read ports, 1 synchronous write port, async reset, bypass under ID_BYPASS_EN).
- Decode and sign-extend are functions in id_stage.

## Test plan
- Reset with n_rst_in=0 mid-cycle → all IDEX outputs 0 immediately. After release, reading r5 gives 0.
- WB writes r8=0x0000_00AA. Next cycle, decode add r3,r8,r0 (0x01001820) → IDEX_rd1=0xAA, ctrl=1_0_0_1_0_0_0_10, rd=3.
- Decode lw r9,-4(r8) (0x8D09FFFC) → imm=0xFFFFFFFC, ctrl alu_src/mem_to_reg/reg_write/mem_read=1, rt=9.
- WB writes r0=0xDEAD → reading r0 returns 0.
- WB writes r4=0x1234 in the same cycle ID reads r4:
  - With ID_BYPASS_EN → IDEX_rd1=0x1234.
  - Without → old value 0.
- beq in decode with MEM_ctrl_pc_src_in=1 → IDEX_ctrl=0 and IDEX_pc still loaded. Unknown opcode 0x3F → ctrl=0.

Source files
------------

// File: rtl/id_stage_pkg.sv
// id_stage_pkg: opcodes, alu_op encodings and control-vector bit positions for the decode stage.
package id_stage_pkg;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam int CTRL_W          = 9;
   localparam int CTRL_REG_DST    = 8;
   localparam int CTRL_ALU_SRC    = 7;
   localparam int CTRL_MEM_TO_REG = 6;
   localparam int CTRL_REG_WRITE  = 5;
   localparam int CTRL_MEM_READ   = 4;
   localparam int CTRL_MEM_WRITE  = 3;
   localparam int CTRL_BRANCH     = 2;
   localparam int CTRL_ALUOP_HI   = 1;
   localparam int CTRL_ALUOP_LO   = 0;
endpackage

// File: rtl/id_stage_regfile.sv
// id_stage_regfile: 32x32 register file, r0 hardwired to zero, two async read ports, one sync write port.
// ID_BYPASS_EN makes the read ports write-through for a same-cycle write-back.
module id_stage_regfile (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [4:0]  ra1_i,
   input  logic [4:0]  ra2_i,
   output logic [31:0] rd1_o,
   output logic [31:0] rd2_o,
   input  logic        we_i,
   input  logic [4:0]  wa_i,
   input  logic [31:0] wd_i
);
   logic [31:0] mem_q [32];

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni)
         for (int i = 0; i < 32; i++) mem_q[i] <= '0;
      else if (we_i && wa_i != 5'd0)
         mem_q[wa_i] <= wd_i;

   always_comb begin
      rd1_o = (ra1_i == 5'd0) ? '0 : mem_q[ra1_i];
      rd2_o = (ra2_i == 5'd0) ? '0 : mem_q[ra2_i];
`ifdef ID_BYPASS_EN
      if (we_i && wa_i == ra1_i && ra1_i != 5'd0) rd1_o = wd_i;
      if (we_i && wa_i == ra2_i && ra2_i != 5'd0) rd2_o = wd_i;
`endif
   end
endmodule

// File: rtl/id_stage.sv
// id_stage: pipeline decode stage; decodes control, reads the register file, sign-extends and loads ID/EX.
// Optional macro ID_BYPASS_EN enables write-through of same-cycle write-back into the read ports.
module id_stage
   import id_stage_pkg::*;
#(
   parameter bit FLUSH_ON_BRANCH = 1'b1
) (
   input  logic              clk_in,
   input  logic              n_rst_in,
   input  logic [31:0]       IFID_pc_in,
   input  logic [31:0]       IFID_ir_in,
   input  logic              MEM_ctrl_pc_src_in,
   input  logic              WB_reg_write_in,
   input  logic [4:0]        WB_write_reg_in,
   input  logic [31:0]       WB_write_data_in,
   output logic [31:0]       IDEX_pc_out,
   output logic [31:0]       IDEX_rd1_out,
   output logic [31:0]       IDEX_rd2_out,
   output logic [31:0]       IDEX_imm_out,
   output logic [4:0]        IDEX_rt_out,
   output logic [4:0]        IDEX_rd_out,
   output logic [CTRL_W-1:0] IDEX_ctrl_out
);
   function automatic logic [CTRL_W-1:0] decode(input logic [5:0] op);
      logic [CTRL_W-1:0] c;
      c = '0;
      case (op)
         OP_RTYPE: begin
            c[CTRL_REG_DST]                 = 1'b1;
            c[CTRL_REG_WRITE]               = 1'b1;
            c[CTRL_ALUOP_HI:CTRL_ALUOP_LO]  = ALUOP_FUNCT;
         end
         OP_LW: begin
            c[CTRL_ALU_SRC]                 = 1'b1;
            c[CTRL_MEM_TO_REG]              = 1'b1;
            c[CTRL_REG_WRITE]               = 1'b1;
            c[CTRL_MEM_READ]                = 1'b1;
            c[CTRL_ALUOP_HI:CTRL_ALUOP_LO]  = ALUOP_ADD;
         end
         OP_SW: begin
            c[CTRL_ALU_SRC]                 = 1'b1;
            c[CTRL_MEM_WRITE]               = 1'b1;
            c[CTRL_ALUOP_HI:CTRL_ALUOP_LO]  = ALUOP_ADD;
         end
         OP_BEQ: begin
            c[CTRL_BRANCH]                  = 1'b1;
            c[CTRL_ALUOP_HI:CTRL_ALUOP_LO]  = ALUOP_SUB;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   function automatic logic [31:0] sext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

   logic [31:0]       rd1, rd2;
   logic [31:0]       pc_q, rd1_q, rd2_q, imm_q;
   logic [4:0]        rt_q, rd_q;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;

   id_stage_regfile u_rf (
      .clk_i  (clk_in),
      .rst_ni (n_rst_in),
      .ra1_i  (IFID_ir_in[25:21]),
      .ra2_i  (IFID_ir_in[20:16]),
      .rd1_o  (rd1),
      .rd2_o  (rd2),
      .we_i   (WB_reg_write_in),
      .wa_i   (WB_write_reg_in),
      .wd_i   (WB_write_data_in)
   );

   // A taken branch in MEM turns the instruction now in decode into a bubble.
   assign ctrl_d = (FLUSH_ON_BRANCH && MEM_ctrl_pc_src_in) ? '0 : decode(IFID_ir_in[31:26]);

   always_ff @(posedge clk_in or negedge n_rst_in)
      if (!n_rst_in) begin
         pc_q   <= '0;
         rd1_q  <= '0;
         rd2_q  <= '0;
         imm_q  <= '0;
         rt_q   <= '0;
         rd_q   <= '0;
         ctrl_q <= '0;
      end else begin
         pc_q   <= IFID_pc_in;
         rd1_q  <= rd1;
         rd2_q  <= rd2;
         imm_q  <= sext16(IFID_ir_in[15:0]);
         rt_q   <= IFID_ir_in[20:16];
         rd_q   <= IFID_ir_in[15:11];
         ctrl_q <= ctrl_d;
      end

   assign IDEX_pc_out   = pc_q;
   assign IDEX_rd1_out  = rd1_q;
   assign IDEX_rd2_out  = rd2_q;
   assign IDEX_imm_out  = imm_q;
   assign IDEX_rt_out   = rt_q;
   assign IDEX_rd_out   = rd_q;
   assign IDEX_ctrl_out = ctrl_q;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed scoreboard bench for id_stage with a reference register-file model.
module tb_id_stage;
   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic [31:0] pc_in = '0, ir_in = '0, wd_in = '0;
   logic        pcsrc_in = 1'b0, we_in = 1'b0;
   logic [4:0]  wa_in = '0;
   logic [31:0] pc_o, rd1_o, rd2_o, imm_o;
   logic [4:0]  rt_o, rd_o;
   logic [8:0]  ctrl_o;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      logic [31:0] pc, rd1, rd2, imm;
      logic [4:0]  rt, rd;
      logic [8:0]  ctrl;
   } exp_t;
   exp_t sb[$];
   logic [31:0] ref_rf [32];

   id_stage dut (
      .clk_in             (clk),
      .n_rst_in           (n_rst),
      .IFID_pc_in         (pc_in),
      .IFID_ir_in         (ir_in),
      .MEM_ctrl_pc_src_in (pcsrc_in),
      .WB_reg_write_in    (we_in),
      .WB_write_reg_in    (wa_in),
      .WB_write_data_in   (wd_in),
      .IDEX_pc_out        (pc_o),
      .IDEX_rd1_out       (rd1_o),
      .IDEX_rd2_out       (rd2_o),
      .IDEX_imm_out       (imm_o),
      .IDEX_rt_out        (rt_o),
      .IDEX_rd_out        (rd_o),
      .IDEX_ctrl_out      (ctrl_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] ref_ctrl(input logic [5:0] op);
      case (op)
         6'b000000: return 9'b1_0_0_1_0_0_0_10;
         6'b100011: return 9'b0_1_1_1_1_0_0_00;
         6'b101011: return 9'b0_1_0_0_0_1_0_00;
         6'b000100: return 9'b0_0_0_0_0_0_1_01;
         default:   return 9'b0;
      endcase
   endfunction

   function automatic logic [31:0] ref_read(input logic [4:0] a, input logic we, input logic [4:0] wa,
                                            input logic [31:0] wd);
      if (a == 5'd0) return 32'd0;
`ifdef ID_BYPASS_EN
      if (we && wa == a) return wd;
`endif
      return ref_rf[a];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_pc"}, pc_o, 32'd0);
      chk({tag, "_rd1"}, rd1_o, 32'd0);
      chk({tag, "_rd2"}, rd2_o, 32'd0);
      chk({tag, "_imm"}, imm_o, 32'd0);
      chk({tag, "_rt"}, {27'd0, rt_o}, 32'd0);
      chk({tag, "_rd"}, {27'd0, rd_o}, 32'd0);
      chk({tag, "_ctrl"}, {23'd0, ctrl_o}, 32'd0);
   endtask

   // Drive one decode cycle: push the expectation, clock, then pop and compare.
   task automatic step(input string tag, input logic [31:0] pc, input logic [31:0] ir, input logic br,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
      exp_t e;
      e.pc   = pc;
      e.rd1  = ref_read(ir[25:21], we, wa, wd);
      e.rd2  = ref_read(ir[20:16], we, wa, wd);
      e.imm  = {{16{ir[15]}}, ir[15:0]};
      e.rt   = ir[20:16];
      e.rd   = ir[15:11];
      e.ctrl = br ? 9'd0 : ref_ctrl(ir[31:26]);
      sb.push_back(e);
      pc_in = pc; ir_in = ir; pcsrc_in = br; we_in = we; wa_in = wa; wd_in = wd;
      @(posedge clk);
      if (we && wa != 5'd0) ref_rf[wa] = wd;
      #1;
      we_in = 1'b0; pcsrc_in = 1'b0;
      e = sb.pop_front();
      chk({tag, "_pc"}, pc_o, e.pc);
      chk({tag, "_rd1"}, rd1_o, e.rd1);
      chk({tag, "_rd2"}, rd2_o, e.rd2);
      chk({tag, "_imm"}, imm_o, e.imm);
      chk({tag, "_rt"}, {27'd0, rt_o}, {27'd0, e.rt});
      chk({tag, "_rd"}, {27'd0, rd_o}, {27'd0, e.rd});
      chk({tag, "_ctrl"}, {23'd0, ctrl_o}, {23'd0, e.ctrl});
   endtask

   initial begin
      clear_model();
      #12;
      chk_zero("reset");
      #10 n_rst = 1'b1;
      @(posedge clk); #1;
      step("read_r5", 32'h4, 32'h00A52820, 1'b0, 1'b0, 5'd0, 32'd0);
      chk("read_r5_lit", rd1_o, 32'd0);
      step("wb_r8", 32'h8, 32'h00000000, 1'b0, 1'b1, 5'd8, 32'h000000AA);
      step("add", 32'hC, 32'h01001820, 1'b0, 1'b0, 5'd0, 32'd0);
      chk("add_rd1_lit", rd1_o, 32'h000000AA);
      chk("add_ctrl_lit", {23'd0, ctrl_o}, 32'h00000122);
      chk("add_rd_lit", {27'd0, rd_o}, 32'd3);
      step("lw", 32'h10, 32'h8D09FFFC, 1'b0, 1'b0, 5'd0, 32'd0);
      chk("lw_imm_lit", imm_o, 32'hFFFFFFFC);
      chk("lw_ctrl_lit", {23'd0, ctrl_o}, 32'h000000F0);
      step("sw", 32'h14, 32'hAD090008, 1'b0, 1'b1, 5'd9, 32'h55AA55AA);
      step("wb_r0", 32'h18, 32'h00000000, 1'b0, 1'b1, 5'd0, 32'h0000DEAD);
      step("read_r0", 32'h1C, 32'h00001020, 1'b0, 1'b0, 5'd0, 32'd0);
      chk("read_r0_lit", rd1_o, 32'd0);
      step("same_cyc_r4", 32'h20, 32'h00801020, 1'b0, 1'b1, 5'd4, 32'h00001234);
`ifdef ID_BYPASS_EN
      chk("bypass_lit", rd1_o, 32'h00001234);
`else
      chk("nobypass_lit", rd1_o, 32'd0);
`endif
      step("read_r4", 32'h24, 32'h00801020, 1'b0, 1'b0, 5'd0, 32'd0);
      step("beq_flush", 32'h28, 32'h10880003, 1'b1, 1'b1, 5'd7, 32'h00000077);
      chk("flush_pc_lit", pc_o, 32'h28);
      step("read_r7", 32'h2C, 32'h00E73820, 1'b0, 1'b0, 5'd0, 32'd0);
      step("beq", 32'h30, 32'h10880003, 1'b0, 1'b0, 5'd0, 32'd0);
      step("bad_op", 32'h34, 32'hFC000000, 1'b0, 1'b0, 5'd0, 32'd0);
      for (int k = 0; k < 24; k++) begin
         logic [5:0] ops [6];
         logic [31:0] ir;
         ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04; ops[4] = 6'h3F; ops[5] = 6'h08;
         ir = $urandom;
         ir[31:26] = ops[$urandom_range(0, 5)];
         step("rand", $urandom, ir, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 7)), $urandom);
      end
      @(negedge clk);
      n_rst = 1'b0;
      #1;
      chk_zero("mid_reset");
      clear_model();
      @(posedge clk); #1;
      n_rst = 1'b1;
      step("post_rst_r8", 32'h40, 32'h01004020, 1'b0, 1'b0, 5'd0, 32'd0);
      chk("post_rst_r8_lit", rd1_o, 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
